// File: rtl/count_seq_pkg.sv
// Shared state encoding and default sizing for the measurement-window sequencer.
package count_seq_pkg;

   localparam int DEF_CNT_W         = 24;
   localparam int DEF_WIN_W         = 24;
   localparam int DEF_SETTLE_CYCLES = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_GATE,
      ST_SETTLE,
      ST_LATCH
   } seq_state_t;

endpackage

// File: rtl/count_window_sequencer_window_timer.sv
// Gate-length down-counter: loads a tick count (zero behaves as one) and
// flags the tick that exhausts the window.
module window_timer #(
   parameter int WIN_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIN_W-1:0] load_val,
   input  logic             tick,
   output logic             done
);

   logic [WIN_W-1:0] count;

   // A zero-length window would never see count==1, so it is promoted to one tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= (load_val == '0) ? WIN_W'(1) : load_val;
      end else if (tick && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = tick && (count == WIN_W'(1));

endmodule

// File: rtl/count_window_sequencer.sv
// Runs one clear/gate/settle/latch measurement cycle of the pulse counter,
// optionally back-to-back, with a host valid/ack result handshake.
module count_window_sequencer
   import count_seq_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int WIN_W         = DEF_WIN_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_en,
   input  logic             start,
   input  logic             continuous,
   input  logic             abort,
   input  logic [WIN_W-1:0] window_len,
   input  logic [CNT_W-1:0] count_p,
   input  logic [CNT_W-1:0] count_m,
   output logic             clr_counts,
   output logic             trigger,
   output logic             busy,
   output logic [CNT_W-1:0] result_p,
   output logic [CNT_W-1:0] result_m,
   output logic             result_valid,
   input  logic             result_ack,
   output logic             overrun
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   seq_state_t       state;
   seq_state_t       next_state;
   logic [SET_W-1:0] settle_cnt;
   logic             timer_done;
   logic             latch_now;
   logic             clear_overrun;

   window_timer #(
      .WIN_W(WIN_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (next_state == ST_CLEAR),
      .load_val (window_len),
      .tick     (tick_en && (state == ST_GATE)),
      .done     (timer_done)
   );

   // Abort overrides every transition, including the latch itself.
   always_comb begin
      next_state    = state;
      latch_now     = 1'b0;
      clear_overrun = 1'b0;
      case (state)
         ST_IDLE:   if (start) next_state = ST_CLEAR;
         ST_CLEAR:  next_state = ST_GATE;
         ST_GATE:   if (timer_done) next_state = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == '0) next_state = ST_LATCH;
         ST_LATCH: begin
            latch_now  = 1'b1;
            next_state = continuous ? ST_CLEAR : ST_IDLE;
         end
         default:   next_state = ST_IDLE;
      endcase
      if (abort) begin
         next_state = ST_IDLE;
         latch_now  = 1'b0;
      end
      clear_overrun = (state == ST_IDLE) && (next_state == ST_CLEAR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         clr_counts <= 1'b0;
         trigger    <= 1'b0;
         busy       <= 1'b0;
         settle_cnt <= '0;
      end else begin
         state      <= next_state;
         clr_counts <= (next_state == ST_CLEAR);
         trigger    <= (next_state == ST_GATE);
         busy       <= (next_state != ST_IDLE);
         if (state != ST_SETTLE) begin
            settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
         end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
         end
      end
   end

   // A latch coinciding with an ack keeps the new result valid and is not an overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_p     <= '0;
         result_m     <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (latch_now) begin
            result_p     <= count_p;
            result_m     <= count_m;
            result_valid <= 1'b1;
         end else if (result_ack) begin
            result_valid <= 1'b0;
         end
         if (clear_overrun) begin
            overrun <= 1'b0;
         end else if (latch_now && result_valid && !result_ack) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule
